// File: rtl/riscv_alu_constants.sv
// riscv_alu_constants: ALU operation codes shared by the ALU and its control.
package riscv_alu_constants;
    localparam logic [3:0] ALUOP_ADD = 4'd0;
    localparam logic [3:0] ALUOP_SUB = 4'd1;
    localparam logic [3:0] ALUOP_AND = 4'd2;
    localparam logic [3:0] ALUOP_OR  = 4'd3;
    localparam logic [3:0] ALUOP_XOR = 4'd4;
    localparam logic [3:0] ALUOP_LES = 4'd5;
    localparam logic [3:0] ALUOP_SLL = 4'd6;
    localparam logic [3:0] ALUOP_SRL = 4'd7;
    localparam logic [3:0] ALUOP_SRA = 4'd8;
endpackage

// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: states, opcodes and datapath select encodings of the multicycle control.
// Defining RISCV_MC_TRAP_EN turns illegal instructions into a sticky trap.
package riscv_mc_pkg;
    import riscv_alu_constants::*;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_ALU_WB, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_ERROR
    } state_t;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [1:0] ALU_A_PC    = 2'd0;
    localparam logic [1:0] ALU_A_OLDPC = 2'd1;
    localparam logic [1:0] ALU_A_RS1   = 2'd2;
    localparam logic [1:0] ALU_A_ZERO  = 2'd3;
    localparam logic [1:0] ALU_B_RS2   = 2'd0;
    localparam logic [1:0] ALU_B_IMM   = 2'd1;
    localparam logic [1:0] ALU_B_FOUR  = 2'd2;
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;
    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;
`ifdef RISCV_MC_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif
endpackage

// File: rtl/riscv_mc_control_if.sv
// riscv_mc_control_if: control <-> datapath/memory signal bundle.
interface riscv_mc_control_if;
    logic [31:0] instr;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        bus_err;
    logic        illegal_insn;
    modport master (
        input  instr, alu_zero, mem_ready,
        output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, bus_err, illegal_insn
    );
    modport slave (
        output instr, alu_zero, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, bus_err, illegal_insn
    );
endinterface

// File: rtl/riscv_alu_decode.sv
// riscv_alu_decode: funct3/funct7 to ALU operation for R- and I-type instructions.
module riscv_alu_decode
    import riscv_alu_constants::*;
    import riscv_mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op,
    output logic       illegal
);
    always_comb begin
        alu_op  = ALUOP_ADD;
        illegal = 1'b0;
        case (funct3)
            3'b000:  alu_op = (funct7_5 && opcode == OP_R) ? ALUOP_SUB : ALUOP_ADD;
            3'b001:  alu_op = ALUOP_SLL;
            3'b010:  alu_op = ALUOP_LES;
            3'b011:  illegal = 1'b1;
            3'b100:  alu_op = ALUOP_XOR;
            3'b101:  alu_op = funct7_5 ? ALUOP_SRA : ALUOP_SRL;
            3'b110:  alu_op = ALUOP_OR;
            default: alu_op = ALUOP_AND;
        endcase
    end
endmodule

// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multicycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with memory timeout.
// Illegal-instruction trapping is enabled by RISCV_MC_TRAP_EN.
module riscv_mc_control
    import riscv_alu_constants::*;
    import riscv_mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic                      clk,
    input logic                      rst_n,
    riscv_mc_control_if.master       bus
);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    state_t     state_q, state_d, nxt;
    logic [7:0] wait_q, wait_d;
    logic       bus_err_q, bus_err_d, illegal_q, illegal_d;
    logic       ill, waiting, dec_illegal;
    logic [3:0] dec_op;
    logic [6:0] opcode;
    logic [2:0] funct3;
    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    riscv_alu_decode u_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (bus.instr[30]),
        .alu_op   (dec_op),
        .illegal  (dec_illegal)
    );
    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        bus_err_d     = bus_err_q;
        illegal_d     = illegal_q;
        nxt           = S_FETCH;
        ill           = 1'b0;
        waiting       = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.addr_sel  = 1'b0;
        bus.ir_write  = 1'b0;
        bus.pc_write  = 1'b0;
        bus.pc_src    = PC_SRC_ALU;
        bus.alu_src_a = ALU_A_PC;
        bus.alu_src_b = ALU_B_RS2;
        bus.alu_op    = ALUOP_ADD;
        bus.reg_write = 1'b0;
        bus.wb_sel    = WB_ALU;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = ALU_B_FOUR;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                    waiting       = !bus.mem_ready;
                    state_d       = bus.mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    bus.alu_src_a = ALU_A_OLDPC;
                    bus.alu_src_b = ALU_B_IMM;
                    case (opcode)
                        OP_R:              begin nxt = S_EXEC_R; ill = dec_illegal; end
                        OP_I:              begin nxt = S_EXEC_I; ill = dec_illegal; end
                        OP_LOAD, OP_STORE: nxt = S_MEM_ADDR;
                        OP_BRANCH:         begin nxt = S_BRANCH; ill = funct3[2:1] != 2'b00; end
                        OP_JAL:            nxt = S_JAL;
                        OP_LUI:            nxt = S_EXEC_LUI;
                        default:           ill = 1'b1;
                    endcase
                    // without trapping an illegal op is a NOP: PC already advanced in FETCH
                    state_d   = !ill ? nxt : (TRAP_EN ? S_ERROR : S_FETCH);
                    illegal_d = illegal_q | (ill & TRAP_EN);
                end
                S_EXEC_R: begin
                    bus.alu_src_a = ALU_A_RS1;
                    bus.alu_op    = dec_op;
                    state_d       = S_ALU_WB;
                end
                S_EXEC_I: begin
                    bus.alu_src_a = ALU_A_RS1;
                    bus.alu_src_b = ALU_B_IMM;
                    bus.alu_op    = dec_op;
                    state_d       = S_ALU_WB;
                end
                S_EXEC_LUI: begin
                    bus.alu_src_a = ALU_A_ZERO;
                    bus.alu_src_b = ALU_B_IMM;
                    state_d       = S_ALU_WB;
                end
                S_ALU_WB: begin
                    bus.reg_write = 1'b1;
                    state_d       = S_FETCH;
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = ALU_A_RS1;
                    bus.alu_src_b = ALU_B_IMM;
                    state_d       = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    bus.mem_req  = 1'b1;
                    bus.addr_sel = 1'b1;
                    waiting      = !bus.mem_ready;
                    state_d      = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
                end
                S_MEM_WB: begin
                    bus.reg_write = 1'b1;
                    bus.wb_sel    = WB_MDR;
                    state_d       = S_FETCH;
                end
                S_MEM_WR: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_we   = 1'b1;
                    bus.addr_sel = 1'b1;
                    waiting      = !bus.mem_ready;
                    state_d      = bus.mem_ready ? S_FETCH : S_MEM_WR;
                end
                S_BRANCH: begin
                    bus.alu_src_a = ALU_A_RS1;
                    bus.alu_op    = ALUOP_SUB;
                    bus.pc_write  = bus.alu_zero ^ funct3[0];
                    bus.pc_src    = PC_SRC_ALUOUT;
                    state_d       = S_FETCH;
                end
                S_JAL: begin
                    bus.reg_write = 1'b1;
                    bus.wb_sel    = WB_PC;
                    bus.pc_write  = 1'b1;
                    bus.pc_src    = PC_SRC_ALUOUT;
                    state_d       = S_FETCH;
                end
                default: state_d = S_ERROR;
            endcase
            // ready on the final allowed cycle clears waiting, so the access completes
            if (waiting && wait_q == WAIT_LAST) begin
                state_d   = S_ERROR;
                bus_err_d = 1'b1;
            end else if (waiting) begin
                wait_d = wait_q + 8'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end
    assign bus.bus_err      = rst_n & bus_err_q;
    assign bus.illegal_insn = TRAP_EN & rst_n & illegal_q;
endmodule

// File: tb/tb_riscv_mc_control.sv
// tb_riscv_mc_control: directed and random instruction streams against a per-instruction cycle model.
module tb_riscv_mc_control;
    import riscv_alu_constants::*;
    localparam logic Y = 1'b1, N = 1'b0;
    localparam logic [1:0] A_PC = 2'd0, A_OLD = 2'd1, A_RS1 = 2'd2, A_ZERO = 2'd3;
    localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_4 = 2'd2;
    localparam logic [1:0] W_ALU = 2'd0, W_MDR = 2'd1, W_PC = 2'd2;
    localparam logic [6:0] OR_ = 7'b0110011, OI = 7'b0010011, OLD = 7'b0000011, OST = 7'b0100011;
    localparam logic [6:0] OBR = 7'b1100011, OJAL = 7'b1101111, OLUI = 7'b0110111;
    typedef struct {
        logic [31:0] ins;
        logic        ready;
        logic        zero;
        logic [18:0] exp;
    } step_t;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0, errors = 0;
    bit   halted = 0;
    step_t q[$];
    logic [6:0] opcs [7] = '{OR_, OI, OLD, OST, OBR, OJAL, OLUI};
    always #5 clk = ~clk;
    riscv_mc_control_if bus();
    riscv_mc_control #(.MEM_TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    function automatic logic [18:0] ov(input logic req, we, asel, irw, pcw, pcs,
                                       input logic [1:0] a, b, input logic [3:0] op,
                                       input logic rw, input logic [1:0] wb,
                                       input logic be = 1'b0, input logic il = 1'b0);
        return {req, we, asel, irw, pcw, pcs, a, b, op, rw, wb, be, il};
    endfunction
    function automatic logic [18:0] got();
        return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write, bus.pc_write, bus.pc_src,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.wb_sel,
                bus.bus_err, bus.illegal_insn};
    endfunction
    function automatic logic rb();
        return 1'($urandom);
    endfunction
    function automatic logic [3:0] ref_op(input logic [2:0] f3, input logic f7, input logic rtype);
        case (f3)
            3'd0:    return (rtype && f7) ? ALUOP_SUB : ALUOP_ADD;
            3'd1:    return ALUOP_SLL;
            3'd2:    return ALUOP_LES;
            3'd4:    return ALUOP_XOR;
            3'd5:    return f7 ? ALUOP_SRA : ALUOP_SRL;
            3'd6:    return ALUOP_OR;
            3'd7:    return ALUOP_AND;
            default: return ALUOP_ADD;
        endcase
    endfunction
    task automatic check(input string tag, input logic [18:0] g, input logic [18:0] e);
        checks++;
        assert (g === e) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, g, e);
        end
    endtask
    task automatic push(input logic [31:0] ins, input logic r, input logic z, input logic [18:0] e);
        q.push_back('{ins, r, z, e});
    endtask
    // Expected per-cycle outputs of one instruction, with fw/mw memory wait cycles
    task automatic add_insn(input logic [31:0] ins, input int fw, input int mw, input logic z);
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7;
        bit         legal;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[30];
        for (int i = 0; i < fw; i++) push(ins, N, rb(), ov(Y,N,N,N,N,N,A_PC,B_4,ALUOP_ADD,N,W_ALU));
        push(ins, Y, rb(), ov(Y,N,N,Y,Y,N,A_PC,B_4,ALUOP_ADD,N,W_ALU));
        push(ins, rb(), rb(), ov(N,N,N,N,N,N,A_OLD,B_IMM,ALUOP_ADD,N,W_ALU));
        legal = ((opc == OR_ || opc == OI) && f3 != 3'd3) || opc == OLD || opc == OST ||
                (opc == OBR && f3 < 3'd2) || opc == OJAL || opc == OLUI;
        if (!legal) begin
`ifdef RISCV_MC_TRAP_EN
            for (int i = 0; i < 3; i++) push(ins, rb(), rb(), ov(N,N,N,N,N,N,A_PC,B_RS2,4'd0,N,W_ALU,N,Y));
            halted = 1;
`endif
            return;
        end
        case (opc)
            OR_: begin
                push(ins, rb(), rb(), ov(N,N,N,N,N,N,A_RS1,B_RS2,ref_op(f3, f7, Y),N,W_ALU));
                push(ins, rb(), rb(), ov(N,N,N,N,N,N,A_PC,B_RS2,4'd0,Y,W_ALU));
            end
            OI: begin
                push(ins, rb(), rb(), ov(N,N,N,N,N,N,A_RS1,B_IMM,ref_op(f3, f7, N),N,W_ALU));
                push(ins, rb(), rb(), ov(N,N,N,N,N,N,A_PC,B_RS2,4'd0,Y,W_ALU));
            end
            OLUI: begin
                push(ins, rb(), rb(), ov(N,N,N,N,N,N,A_ZERO,B_IMM,ALUOP_ADD,N,W_ALU));
                push(ins, rb(), rb(), ov(N,N,N,N,N,N,A_PC,B_RS2,4'd0,Y,W_ALU));
            end
            OLD, OST: begin
                push(ins, rb(), rb(), ov(N,N,N,N,N,N,A_RS1,B_IMM,ALUOP_ADD,N,W_ALU));
                for (int i = 0; i <= mw; i++)
                    push(ins, i == mw, rb(), ov(Y,opc == OST,Y,N,N,N,A_PC,B_RS2,4'd0,N,W_ALU));
                if (opc == OLD) push(ins, rb(), rb(), ov(N,N,N,N,N,N,A_PC,B_RS2,4'd0,Y,W_MDR));
            end
            OBR: push(ins, rb(), z, ov(N,N,N,N,z ^ f3[0],Y,A_RS1,B_RS2,ALUOP_SUB,N,W_ALU));
            default: push(ins, rb(), rb(), ov(N,N,N,N,Y,Y,A_PC,B_RS2,4'd0,Y,W_PC));
        endcase
    endtask
    task automatic run_n(input string tag, input int n);
        step_t s;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            s = q.pop_front();
            bus.instr     = s.ins;
            bus.mem_ready = s.ready;
            bus.alu_zero  = s.zero;
            #1 check(tag, got(), s.exp);
            @(posedge clk);
            #1;
        end
    endtask
    task automatic do_reset();
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.alu_zero  = 1'b1;
        #1 check("reset_now", got(), '0);
        repeat (3) begin
            @(posedge clk);
            #1 check("reset", got(), '0);
        end
        rst_n  = 1'b1;
        halted = 0;
    endtask
    task automatic go(input string tag, input logic [31:0] ins, input int fw, input int mw, input logic z);
        add_insn(ins, fw, mw, z);
        run_n(tag, 1000);
        if (halted) do_reset();
    endtask
    initial begin
        logic [31:0] ins;
        rst_n         = 1'b0;
        bus.instr     = '0;
        bus.mem_ready = 1'b0;
        bus.alu_zero  = 1'b0;
        do_reset();
        go("add",   32'h002081B3, 2, 0, N);
        go("sub",   32'h40208133, 0, 0, N);
        go("sra",   32'h4020D1B3, 1, 0, N);
        go("addi",  32'hFFF00093, 0, 0, N);
        go("beq_t", 32'h00208463, 0, 0, Y);
        go("beq_n", 32'h00208463, 0, 0, N);
        go("bne_t", 32'h00209463, 0, 0, Y);
        go("bne_n", 32'h00209463, 0, 0, N);
        go("lw",    32'h0000A183, 0, 1, N);
        go("sw",    32'h0030A023, 1, 2, N);
        go("jal",   32'h0000006F, 0, 0, N);
        go("lui",   32'h123450B7, 0, 0, N);
        go("fetch_edge", 32'h002081B3, 7, 0, N);
        go("lw_edge",    32'h0000A183, 0, 7, N);
        go("sw_edge",    32'h0030A023, 0, 7, N);
        go("sltu",  32'h0020B1B3, 0, 0, N);
        go("blt",   32'h0020C463, 0, 0, N);
        go("ones",  32'hFFFFFFFF, 0, 0, N);
        add_insn(32'h0000A183, 0, 2, N);
        run_n("mid_rst", 3);
        q.delete();
        do_reset();
        go("post_rst", 32'h002081B3, 0, 0, N);
        for (int n = 0; n < 80; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) != 0) ins[6:0] = opcs[$urandom_range(0, 6)];
            if (ins[6:0] == OBR && $urandom_range(0, 3) != 0) ins[14:13] = 2'b00;
            go("rand", ins, $urandom_range(0, 3), $urandom_range(0, 3), rb());
        end
        for (int i = 0; i < 8; i++) push(32'h0, N, rb(), ov(Y,N,N,N,N,N,A_PC,B_4,ALUOP_ADD,N,W_ALU));
        for (int i = 0; i < 4; i++) push(32'h0, rb(), rb(), ov(N,N,N,N,N,N,A_PC,B_RS2,4'd0,N,W_ALU,Y,N));
        run_n("timeout", 1000);
        do_reset();
        go("recover", 32'h0000A183, 0, 0, N);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
